div_unit: RTL and testbench
===========================

// Module: div_unit
//
// PURPOSE
//   Multicycle signed 32-bit divider (MIPS DIV semantics): restoring shift-subtract, one quotient bit per clock.
//   Drives the HI/LO registers; their outputs feed the register-file write-data select mux.
//   Raises a divide-by-zero flag consumed by the control unit's exception handling.
//
// PARAMETERS
//   WIDTH  32  operand/result width; iteration count equals WIDTH
//
// PORTS
//   clk          in   1      system clock, all state updates on rising edge
//   reset        in   1      synchronous, active-high
//   start        in   1      request; sampled only while idle (busy=0)
//   dividend     in   WIDTH  numerator (rs), latched on accepted start
//   divisor      in   WIDTH  denominator (rt), latched on accepted start
//   busy         out  1      operation in progress
//   done         out  1      one-cycle completion pulse
//   div_zero     out  1      one-cycle pulse with done when divisor was 0
//   hi_out       out  WIDTH  remainder (to HI register)
//   lo_out       out  WIDTH  quotient (to LO register)
//
// BEHAVIOUR
//   - One clock; reset is synchronous, active-high; no asynchronous paths.
//   - Reset (takes priority over everything, also mid-operation): state=IDLE; busy, done, div_zero, hi_out, lo_out = 0.
//   - FSM: IDLE -> CALC -> FIX -> IDLE; IDLE -> ZERO -> IDLE.
//   - IDLE: start=1 at edge E0 latches operands and sets busy=1.
//     - If divisor==0: go to ZERO.
//     - Otherwise: store |dividend|, |divisor| and both signs; clear remainder; count=0; go to CALC.
//   - CALC: each edge does
//     - rem = {rem[W-2:0], quo[W-1]} and quo <<= 1.
//     - If rem >= |divisor|: rem -= |divisor| and quo[0] = 1.
//     - Go to FIX after WIDTH iterations (edges E1..E32).
//   - FIX (edge E33): results, busy and done are all written on this edge.
//     - lo_out = quotient, negated if the operand signs differ.
//     - hi_out = remainder, negated if the dividend was negative.
//     - busy=0, done=1 for exactly one cycle; return to IDLE.
//   - Latency: done visible after edge E(WIDTH+1) = E33; a new start is accepted on the very next edge.
//   - ZERO (edge E1): busy=0, done=1, div_zero=1 (one cycle); hi_out/lo_out unchanged.
//   - Rounding: quotient truncates toward zero; the remainder takes the sign of the dividend.
//   - Overflow: 0x80000000 / 0xFFFFFFFF wraps to lo=0x80000000, hi=0; no flag is raised.
//   - Negation is two's complement modulo 2^WIDTH; the magnitude of 0x80000000 is 0x80000000 unsigned.
//   - start while busy=1: ignored. Latched operands and progress are unaffected by input changes.
//   - hi_out/lo_out hold their last value until the next FIX edge or reset.
//   - done and div_zero are registered, never combinational from start.
//
// CONFIGURATION
//   DIV_UNSIGNED_EN defined:
//     - Adds port is_unsigned (in, 1), latched on an accepted start.
//     - If latched 1: operands are treated as unsigned magnitudes with no sign fix (DIVU); FIX writes raw quo/rem.
//     - Latency and the divide-by-zero path are identical to signed mode.
//   DIV_UNSIGNED_EN undefined:
//     - No is_unsigned port; every operation is signed DIV.
//
// TESTING
//   1. Basic: reset, then start, 7 / 2 -> E33: done=1, lo=3, hi=1, busy=0; done low at E34.
//   2. Signs: -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      7 / -2 -> lo=0xFFFFFFFD, hi=1.
//      -8 / -2 -> lo=4, hi=0.
//   3. Divide by zero: after test 1, 100 / 0 -> E1: done=1, div_zero=1; hi=1, lo=3 retained.
//   4. Overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//   5. Interference: start 50 / 5; at E10 pulse start with 9 / 3 -> ignored; E33: lo=10, hi=0.
//      Repeat with reset=1 at E10 -> E11: busy=0, hi=lo=0, and no done pulse thereafter.
//   6. DIV_UNSIGNED_EN, is_unsigned=1: 0xFFFFFFFF / 2 -> lo=0x7FFFFFFF, hi=1.
//      Same operands with is_unsigned=0 -> lo=0, hi=0xFFFFFFFF.

Source files
------------

// File: rtl/div_unit.sv
// div_unit -- multicycle 32-bit divider (MIPS DIV, optionally DIVU)
//
// Restoring shift-subtract, one quotient bit per clock. Operands are reduced
// to magnitudes on accept, divided unsigned, and the signs are re-applied on
// the final FIX cycle. Divide by zero skips the loop and leaves HI/LO as-is.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            request, sampled only while idle
//   dividend/divisor operands (rs/rt), latched on an accepted start
//   is_unsigned      (DIV_UNSIGNED_EN only) 1 = DIVU, latched on accept
//   busy             operation in progress
//   done             one-cycle completion pulse
//   div_zero         one-cycle pulse alongside done when divisor was 0
//   hi_out / lo_out  remainder / quotient, held until next FIX or reset
//
// Build option: define DIV_UNSIGNED_EN to add the is_unsigned port.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;

    state_t           state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;

    // Signed handling only applies to DIV; DIVU passes operands through raw.
    logic signed_op;
`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~is_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign abs_b = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Shifted partial remainder needs WIDTH+1 bits: in unsigned mode the
    // divisor can reach 2^WIDTH-1, so the bit shifted out of rem still counts.
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] sub;
    logic [WIDTH-1:0] rem_nxt;

    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        ge      = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= dvs);
        // True difference is < dvs, so the low WIDTH bits are exact.
        sub     = rem_sh[WIDTH-1:0] - dvs;
        rem_nxt = ge ? sub : rem_sh[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= signed_op & dividend[WIDTH-1];
                        if (divisor == '0) begin
                            state <= ZERO;
                        end else begin
                            quo   <= abs_a;
                            dvs   <= abs_b;
                            rem   <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    lo_out <= neg_q ? -quo : quo;
                    hi_out <= neg_r ? -rem : rem;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                ZERO: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- scoreboard bench for div_unit. Expected results come from a
// magnitude-based reference model pushed at start; popped on done.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         is_u;
    logic         busy, done, div_zero;
    logic [W-1:0] hi_out, lo_out;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned(is_u),
`endif
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] last_hi = '0, last_lo = '0;
    int           n_run = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic u, input logic [W-1:0] ph,
                                   input logic [W-1:0] pl);
        exp_t e;
        logic [W-1:0] ma, mb, q, r;
        if (b == '0) begin
            e.hi = ph; e.lo = pl; e.dz = 1'b1;
        end else begin
            ma = (!u && a[W-1]) ? -a : a;
            mb = (!u && b[W-1]) ? -b : b;
            q  = ma / mb;
            r  = ma % mb;
            if (!u && (a[W-1] ^ b[W-1])) q = -q;
            if (!u && a[W-1]) r = -r;
            e.hi = r; e.lo = q; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drive an accepted start (edge E0), push the expectation, scramble inputs.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        exp_t e;
        start = 1'b1; dividend = a; divisor = b; is_u = u;
        e = model(a, b, u, last_hi, last_lo);
        sb.push_back(e);
        last_hi = e.hi; last_lo = e.lo;
        tick();
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_u = $urandom_range(0, 1);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Wait (bounded) for done; check latency from now, results, and pulse width.
    task automatic finish_op(input int exp_lat);
        exp_t e;
        int   n = 0;
        while (!done && n < 60) begin
            tick(); n++;
        end
        chk("latency", n, exp_lat);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk("hi", hi_out, e.hi);
            chk("lo", lo_out, e.lo);
            chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
            chk("busy_at_done", {31'b0, busy}, 32'd0);
        end else begin
            chk("done_seen", {31'b0, done}, 32'd1);
        end
        tick();
        chk("done_low_next", {31'b0, done}, 32'd0);
        chk("dz_low_next", {31'b0, div_zero}, 32'd0);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        start_op(a, b, u);
        finish_op(b == '0 ? 1 : W + 1);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_u = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dz", {31'b0, div_zero}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        reset = 1'b0;
        tick();

        // Basic and sign combinations, with literal cross-checks.
        run(32'd7, 32'd2, 1'b0);
        chk("lo_7_2", lo_out, 32'd3);
        chk("hi_7_2", hi_out, 32'd1);
        run(-32'sd7, 32'd2, 1'b0);
        chk("lo_m7_2", lo_out, 32'hFFFF_FFFD);
        chk("hi_m7_2", hi_out, 32'hFFFF_FFFF);
        run(32'd7, -32'sd2, 1'b0);
        chk("lo_7_m2", lo_out, 32'hFFFF_FFFD);
        chk("hi_7_m2", hi_out, 32'd1);
        run(-32'sd8, -32'sd2, 1'b0);
        chk("lo_m8_m2", lo_out, 32'd4);
        chk("hi_m8_m2", hi_out, 32'd0);

        // Divide by zero retains previous results.
        run(32'd7, 32'd2, 1'b0);
        run(32'd100, 32'd0, 1'b0);
        chk("lo_dz_keep", lo_out, 32'd3);
        chk("hi_dz_keep", hi_out, 32'd1);

        // Overflow wraps.
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("lo_ovf", lo_out, 32'h8000_0000);
        chk("hi_ovf", hi_out, 32'd0);

        // Random signed operands.
        for (int i = 0; i < 6; i++) run($urandom, $urandom, 1'b0);
        run($urandom, $urandom_range(1, 9), 1'b0);

        // start while busy is ignored.
        start_op(32'd50, 32'd5, 1'b0);
        repeat (9) tick();
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        tick();
        start = 1'b0;
        finish_op(W + 1 - 10);
        chk("lo_interf", lo_out, 32'd10);
        chk("hi_interf", hi_out, 32'd0);

        // Reset mid-operation aborts with no done pulse.
        start_op(32'd50, 32'd5, 1'b0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        sb.delete();
        last_hi = '0; last_lo = '0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_lo", lo_out, 32'd0);
        cnt = 0;
        repeat (40) begin
            tick();
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 32'd0);

`ifdef DIV_UNSIGNED_EN
        run(32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("lo_divu", lo_out, 32'h7FFF_FFFF);
        chk("hi_divu", hi_out, 32'd1);
        run(32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("lo_div_s", lo_out, 32'd0);
        chk("hi_div_s", hi_out, 32'hFFFF_FFFF);
        run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
        run(32'd5, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) run($urandom, $urandom, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
